// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the 32-bit pattern generator and checker:
// word width, tap positions, checker state encoding and the step function.
package lfsr_pkg;

  localparam int unsigned LFSR_N = 32;
  localparam int unsigned TAP_A  = 31;
  localparam int unsigned TAP_B  = 21;
  localparam int unsigned TAP_C  = 1;
  localparam int unsigned TAP_D  = 0;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  // One shift-left step with the XOR of the four taps fed into bit 0.
  function automatic logic [LFSR_N-1:0] lfsr_step(input logic [LFSR_N-1:0] cur);
    return {cur[LFSR_N-2:0], cur[TAP_A] ^ cur[TAP_B] ^ cur[TAP_C] ^ cur[TAP_D]};
  endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with a per-cycle increment amount and synchronous clear.
module lfsr_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic [W-1:0] inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W:0]   sum_c;

  // One extra bit catches the wrap so the count pins at all-ones.
  assign sum_c = {1'b0, count_q} + {1'b0, inc_i};

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      count_q <= '0;
    end else if (sum_c[W]) begin
      count_q <= '1;
    end else begin
      count_q <= sum_c[W-1:0];
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR stream checker: self-synchronises, then flags and counts errors.
// Optional LFSR_CHECKER_BITERR_EN adds a saturating bit-error counter output.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned N        = 32,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [N-1:0]     data_in,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
`ifdef LFSR_CHECKER_BITERR_EN
  ,
  output logic [CNT_W-1:0] bit_err_count
`endif
);

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_CNT - 1);

  chk_state_e   state_q;
  logic [N-1:0] expected_q;
  logic [3:0]   run_q;
  logic         err_flag_q;

  logic match_c;
  logic nonzero_c;
  logic word_inc_c;
  logic err_inc_c;

  assign match_c    = (data_in == expected_q);
  assign nonzero_c  = (data_in != '0);
  assign word_inc_c = valid_in && (state_q == ST_LOCKED);
  assign err_inc_c  = word_inc_c && !match_c;

  // Acquisition/tracking FSM; while locked the prediction free-runs from itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_SEARCH;
      expected_q <= '0;
      run_q      <= '0;
      err_flag_q <= 1'b0;
    end else begin
      err_flag_q <= 1'b0;
      if (valid_in) begin
        case (state_q)
          ST_SEARCH: begin
            if (nonzero_c) begin
              expected_q <= lfsr_step(data_in);
              run_q      <= '0;
              state_q    <= ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            run_q <= '0;
            if (match_c) begin
              expected_q <= lfsr_step(data_in);
              if (run_q == LOCK_LAST) begin
                state_q <= ST_LOCKED;
              end else begin
                run_q <= run_q + 4'd1;
              end
            end else if (nonzero_c) begin
              expected_q <= lfsr_step(data_in);
            end else begin
              state_q <= ST_SEARCH;
            end
          end
          ST_LOCKED: begin
            expected_q <= lfsr_step(expected_q);
            if (match_c) begin
              run_q <= '0;
            end else begin
              err_flag_q <= 1'b1;
              if (run_q == LOSS_LAST) begin
                run_q   <= '0;
                state_q <= ST_SEARCH;
              end else begin
                run_q <= run_q + 4'd1;
              end
            end
          end
          default: begin
            state_q <= ST_SEARCH;
            run_q   <= '0;
          end
        endcase
      end
    end
  end

  assign locked   = (state_q == ST_LOCKED);
  assign err_flag = err_flag_q;

  lfsr_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear_cnt),
    .inc_i   (CNT_W'(err_inc_c)),
    .count_o (err_count)
  );

  lfsr_sat_counter #(.W(CNT_W)) u_word_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear_cnt),
    .inc_i   (CNT_W'(word_inc_c)),
    .count_o (word_count)
  );

`ifdef LFSR_CHECKER_BITERR_EN
  localparam int unsigned POP_W = $clog2(N + 1);

  logic [N-1:0]     diff_c;
  logic [POP_W-1:0] pop_c;

  assign diff_c = data_in ^ expected_q;

  always_comb begin
    pop_c = '0;
    for (int i = 0; i < N; i++) begin
      pop_c = pop_c + POP_W'(diff_c[i]);
    end
  end

  lfsr_sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear_cnt),
    .inc_i   (word_inc_c ? CNT_W'(pop_c) : '0),
    .count_o (bit_err_count)
  );
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed-vector bench for lfsr_checker; bit-error checks active with LFSR_CHECKER_BITERR_EN.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] data_in;
  logic        clear_cnt;
  logic        locked;
  logic        err_flag;
  logic [15:0] err_count;
  logic [15:0] word_count;
`ifdef LFSR_CHECKER_BITERR_EN
  logic [15:0] bit_err_count;
`endif

  lfsr_checker dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .clear_cnt  (clear_cnt),
    .locked     (locked),
    .err_flag   (err_flag),
    .err_count  (err_count),
    .word_count (word_count)
`ifdef LFSR_CHECKER_BITERR_EN
    ,
    .bit_err_count (bit_err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] data;
    logic        clr;
    logic        e_lock;
    logic        e_err;
    logic [15:0] e_ec;
    logic [15:0] e_wc;
    logic [15:0] e_bec;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] s[0:39];
  int          n_pass  = 0;
  int          n_total = 0;

  function automatic logic [31:0] ref_step(input logic [31:0] x);
    logic fb;
    fb = x[31] ^ x[21] ^ x[1] ^ x[0];
    return {x[30:0], fb};
  endfunction

  task automatic add(input logic rst, input logic vld, input logic [31:0] data,
                     input logic clr, input logic lk, input logic er,
                     input int ec, input int wc, input int bec);
    vec_t v;
    v.rst = rst; v.vld = vld; v.data = data; v.clr = clr;
    v.e_lock = lk; v.e_err = er;
    v.e_ec = 16'(ec); v.e_wc = 16'(wc); v.e_bec = 16'(bec);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic apply(input logic rst, input logic vld, input logic [31:0] data,
                       input logic clr);
    @(negedge clk);
    reset = rst; valid_in = vld; data_in = data; clear_cnt = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input int idx, input vec_t v);
    chk("locked", idx, 32'(locked), 32'(v.e_lock));
    chk("err_flag", idx, 32'(err_flag), 32'(v.e_err));
    chk("err_count", idx, 32'(err_count), 32'(v.e_ec));
    chk("word_count", idx, 32'(word_count), 32'(v.e_wc));
`ifdef LFSR_CHECKER_BITERR_EN
    chk("bit_err_count", idx, 32'(bit_err_count), 32'(v.e_bec));
`endif
  endtask

  initial begin
    vec_t hv;
    reset = 1'b1; valid_in = 1'b0; data_in = '0; clear_cnt = 1'b0;

    s[0] = 32'h1;
    for (int i = 1; i < 40; i++) s[i] = ref_step(s[i-1]);

    //   rst vld data            clr lock err ec wc bec
    add(1, 0, 32'h0,            0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h0,            0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h0,            0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h0,            0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h00000001,     0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h00000003,     0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h00000006,     0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h0000000D,     0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h0000001B,     0, 1, 0, 0, 0, 0);
    add(0, 1, 32'h00000036,     0, 1, 0, 0, 1, 0);
    add(0, 1, 32'h00000000,     0, 1, 1, 1, 2, 5);  // replaces 0x6D
    add(0, 1, 32'h000000DB,     0, 1, 0, 1, 3, 5);
    add(0, 0, 32'hFFFFFFFF,     0, 1, 0, 1, 3, 5);
    add(0, 0, 32'h12345678,     0, 1, 0, 1, 3, 5);
    add(0, 1, s[8],             0, 1, 0, 1, 4, 5);
    add(0, 1, s[9],             0, 1, 0, 1, 5, 5);
    add(0, 1, s[10] ^ 32'h1,    0, 1, 1, 2, 6, 6);
    add(0, 1, s[11] ^ 32'h1,    0, 1, 1, 3, 7, 7);
    add(0, 1, s[12] ^ 32'h1,    0, 0, 1, 4, 8, 8);
    add(0, 1, s[13],            0, 0, 0, 4, 8, 8);
    add(0, 1, s[14],            0, 0, 0, 4, 8, 8);
    add(0, 1, s[15],            0, 0, 0, 4, 8, 8);
    add(0, 1, s[16],            0, 0, 0, 4, 8, 8);
    add(0, 1, s[17],            0, 1, 0, 4, 8, 8);
    add(0, 1, s[18],            0, 1, 0, 4, 9, 8);
    add(0, 1, s[19] ^ 32'h80,   1, 1, 1, 0, 0, 0);
    add(0, 1, s[20],            0, 1, 0, 0, 1, 0);
    add(0, 1, s[21] ^ 32'h7,    0, 1, 1, 1, 2, 3);
    add(0, 1, s[22] ^ 32'h1,    0, 1, 1, 2, 3, 4);
    add(0, 1, s[23],            0, 1, 0, 2, 4, 4);
    add(0, 1, s[24] ^ 32'h1,    0, 1, 1, 3, 5, 5);
    add(0, 1, s[25],            0, 1, 0, 3, 6, 5);
    // mismatch during VERIFY reseeds from the received word
    add(1, 0, 32'h0,            0, 0, 0, 0, 0, 0);
    add(0, 1, s[0],             0, 0, 0, 0, 0, 0);
    add(0, 1, s[1],             0, 0, 0, 0, 0, 0);
    add(0, 1, s[5],             0, 0, 0, 0, 0, 0);
    add(0, 1, s[6],             0, 0, 0, 0, 0, 0);
    add(0, 1, s[7],             0, 0, 0, 0, 0, 0);
    add(0, 1, s[8],             0, 0, 0, 0, 0, 0);
    add(0, 1, s[9],             0, 1, 0, 0, 0, 0);
    // zero word during VERIFY returns to SEARCH
    add(1, 0, 32'h0,            0, 0, 0, 0, 0, 0);
    add(0, 1, s[0],             0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h0,            0, 0, 0, 0, 0, 0);
    add(0, 1, s[1],             0, 0, 0, 0, 0, 0);
    add(0, 1, s[2],             0, 0, 0, 0, 0, 0);
    add(0, 1, s[3],             0, 0, 0, 0, 0, 0);
    add(0, 1, s[4],             0, 0, 0, 0, 0, 0);
    add(0, 1, s[5],             0, 1, 0, 0, 0, 0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].vld, vecs[i].data, vecs[i].clr);
      check_outs(i, vecs[i]);
    end

    // long idle gap while locked: nothing may move
    for (int i = 0; i < 12; i++) begin
      apply(0, 0, $urandom, 0);
      chk("gap_locked", 100 + i, 32'(locked), 32'd1);
      chk("gap_wc", 100 + i, 32'(word_count), 32'd0);
      chk("gap_err", 100 + i, 32'(err_flag), 32'd0);
    end
    apply(0, 1, s[6], 0);
    chk("post_gap_wc", 200, 32'(word_count), 32'd1);
    chk("post_gap_err", 200, 32'(err_count), 32'd0);

    // err_flag is a single-cycle pulse
    apply(0, 1, s[7] ^ 32'h10, 0);
    chk("pulse_hi", 201, 32'(err_flag), 32'd1);
    apply(0, 0, 32'h0, 0);
    chk("pulse_lo", 202, 32'(err_flag), 32'd0);
    chk("pulse_ec", 202, 32'(err_count), 32'd1);
    apply(0, 1, s[8], 0);
    chk("recover_lock", 203, 32'(locked), 32'd1);
    chk("recover_wc", 203, 32'(word_count), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
